fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage driving the IF/ID pipeline register from the writer side. Holds the PC, issues single-outstanding requests to instruction memory, and presents instruction, PC and PC+4 with the IF/ID enable/flush controls. It absorbs variable memory latency, back-pressure from the hazard unit, and branch/jump redirects, including redirects that arrive while a request is in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word-aligned
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req_valid  output  1  request to instruction memory
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  32  request address (current PC)
- imem_resp_valid  input  1  response data valid this cycle
- imem_resp_data  input  32  fetched instruction word
- stall_in  input  1  hazard unit: IF/ID must hold
- redirect_valid  input  1  branch/jump taken; refetch from redirect_pc
- redirect_pc  input  32  target PC; bits [1:0] ignored (forced 0)
- ifid_enable  output  1  drives IF/ID enable
- ifid_flush  output  1  drives IF/ID reset (bubble insert)
- instr_out  output  32  instruction to IF/ID
- pc_out  output  32  PC of instr_out
- pc4_out  output  32  pc_out + 4

## Operation
- States: REQ, WAIT, HOLD, DROP. Reset: state=REQ, pc=RESET_PC, buffer=0; all outputs 0 during the reset cycle (imem_req_valid=0, ifid_enable=0, ifid_flush=0).
- REQ: imem_req_valid=1, imem_addr=pc; imem_req_ready -> WAIT.
- WAIT: on imem_resp_valid: if !stall_in, ifid_enable=1, instr_out=imem_resp_data, pc<=pc+4, -> REQ; if stall_in, latch data into buffer, -> HOLD.
- HOLD: instr_out=buffer; ifid_enable=!stall_in; on release pc<=pc+4, -> REQ.
- DROP: a redirected-away request is still outstanding; next imem_resp_valid is discarded, -> REQ.
- Redirect (highest priority, any state): ifid_flush=1, ifid_enable=0, imem_req_valid=0, pc<={redirect_pc[31:2],2'b00}. Next state: REQ from REQ/HOLD; from WAIT -> REQ if imem_resp_valid same cycle (response discarded), else DROP; from DROP stays DROP.
- ifid_flush overrides stall_in; stall_in never blocks a flush.
- pc_out=pc, pc4_out=pc+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- instr_out/pc_out/pc4_out are don't-care when ifid_enable=0 but must be 0 during reset.
- imem_resp_valid in REQ or HOLD is ignored (stale response after reset).

## Timing
- ifid_enable, ifid_flush, instr_out, imem_req_valid are combinational from state and inputs; pc and state registered.
- Zero-wait memory (ready in REQ, resp next cycle): one instruction every 2 cycles; instruction visible at IF/ID output the edge after resp.
- Redirect-to-request: imem_req_valid for target asserts the cycle after redirect_valid (one extra cycle in DROP per outstanding response).
- Reset mid-operation: next cycle in REQ with pc=RESET_PC regardless of prior state; buffered data lost.
- At most one request outstanding; imem_req_valid never asserted in WAIT/HOLD/DROP.

## Structure
- cpu_pkg: fetch_state_t enum (REQ, WAIT, HOLD, DROP), NOP encoding 32'h0000_0013, PC increment constant 4.
- No sub-module; single always block for state/pc/buffer plus combinational output logic.

## Test plan
- Reset release, memory always ready, 1-cycle latency -> addresses 0x0, 0x4, 0x8 requested every 2 cycles; ifid_enable pulses with pc_out/pc4_out = 0/4, 4/8, 8/C.
- stall_in high 3 cycles when response 0xDEADBEEF arrives -> HOLD, ifid_enable=0 for 3 cycles, then 1 cycle with instr_out=0xDEADBEEF, next request at pc+4.
- redirect_valid to 0x1003 in WAIT without response -> ifid_flush=1, DROP; stale response discarded (ifid_enable=0); next request at 0x1000.
- redirect_valid and stall_in same cycle in HOLD -> ifid_flush=1, ifid_enable=0, buffer discarded, next request at target.
- RESET_PC=0xFFFF_FFFC -> pc4_out=0, second request at 0x0000_0000.
- reset asserted in WAIT with imem_resp_valid the following cycle -> response ignored, request reissued at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, NOP word, PC step.
package cpu_pkg;

    // REQ: ready to issue, WAIT: request in flight, HOLD: response parked while
    // IF/ID is stalled, DROP: in-flight request belongs to a squashed path.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    // Sequential successor of a PC; wraps naturally at 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one memory request in
// flight, and feeds the IF/ID register (enable/flush plus instr, pc, pc+4).
// Redirects win over everything; a response belonging to a squashed request
// is swallowed in DROP so the new path never sees it.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_enable,
    output logic        ifid_flush,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out
);

    // Force word alignment even if the parameter is set carelessly.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_buf;

    logic [31:0]  w_redirect_target;
    logic [31:0]  w_pc_plus4;
    logic         w_req_valid;
    logic         w_enable;
    logic         w_flush;
    logic [31:0]  w_instr;
    logic [31:0]  w_addr;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc4;

    assign w_redirect_target = redirect_pc & ~32'd3;
    assign w_pc_plus4        = pc_next(r_pc);

    // Output decode: reset blanks everything, a redirect only flushes, otherwise
    // the state decides whether to request or to hand an instruction to IF/ID.
    always_comb begin
        w_req_valid = 1'b0;
        w_enable    = 1'b0;
        w_flush     = 1'b0;
        w_instr     = NOP_INSTR;
        w_addr      = r_pc;
        w_pc        = r_pc;
        w_pc4       = w_pc_plus4;
        if (reset) begin
            w_instr = '0;
            w_addr  = '0;
            w_pc    = '0;
            w_pc4   = '0;
        end else if (redirect_valid) begin
            w_flush = 1'b1;
        end else begin
            case (r_state)
                REQ: begin
                    w_req_valid = 1'b1;
                end
                WAIT: begin
                    if (imem_resp_valid && !stall_in) begin
                        w_enable = 1'b1;
                        w_instr  = imem_resp_data;
                    end
                end
                HOLD: begin
                    w_enable = !stall_in;
                    w_instr  = r_buf;
                end
                default: begin
                    // DROP: nothing to present, nothing to issue.
                end
            endcase
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = w_addr;
    assign ifid_enable    = w_enable;
    assign ifid_flush     = w_flush;
    assign instr_out      = w_instr;
    assign pc_out         = w_pc;
    assign pc4_out        = w_pc4;

    // State, PC and parked-response buffer; redirect takes priority over the
    // normal request/response sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= REQ;
            r_pc    <= RESET_PC_ALIGNED;
            r_buf   <= '0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
            case (r_state)
                // The squashed request's response may land this very cycle;
                // if so it is consumed here, otherwise wait for it in DROP.
                // DROP treats a same-cycle response the same way so the FSM
                // never waits for a response that has already come and gone.
                WAIT:    r_state <= imem_resp_valid ? REQ : DROP;
                DROP:    r_state <= imem_resp_valid ? REQ : DROP;
                default: r_state <= REQ;
            endcase
        end else begin
            case (r_state)
                REQ: begin
                    if (imem_req_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (stall_in) begin
                            r_buf   <= imem_resp_data;
                            r_state <= HOLD;
                        end else begin
                            r_pc    <= w_pc_plus4;
                            r_state <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= REQ;
                    end
                end
                DROP: begin
                    if (imem_resp_valid) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

endmodule
